// File: rtl/srff_bank.sv
// rtl/srff_bank.sv - bank of WIDTH set/reset flip-flops with edge pulses and sticky conflict flags
// Optional conflict counter enabled by defining SRFF_BANK_STATS_EN.
module srff_bank #(
  parameter int               WIDTH   = 8,
  parameter int               MODE    = 0,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             clr_conf,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] conf_cnt
);

  generate
    if (MODE < 0 || MODE > 3) begin : g_bad_mode
      $error("srff_bank: MODE must be 0..3");
    end
  endgenerate

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] conf_hit;

  assign conf_hit = s & r & {WIDTH{~load}};

  always_comb begin
    q_next = q;
    if (load) begin
      q_next = load_data;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({s[i], r[i]})
          2'b10:   q_next[i] = 1'b1;
          2'b01:   q_next[i] = 1'b0;
          2'b11: begin
            // S&R resolution selected at elaboration
            if (MODE == 0)      q_next[i] = 1'b0;
            else if (MODE == 1) q_next[i] = 1'b1;
            else if (MODE == 2) q_next[i] = ~q[i];
            else                q_next[i] = q[i];
          end
          default: q_next[i] = q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= RST_VAL;
      rise     <= '0;
      fall     <= '0;
      conflict <= '0;
    end else begin
      q        <= q_next;
      rise     <= q_next & ~q;
      fall     <= q & ~q_next;
      // a fresh conflict wins over a simultaneous clear
      conflict <= (clr_conf ? '0 : conflict) | conf_hit;
    end
  end

`ifdef SRFF_BANK_STATS_EN
  localparam int PW = $clog2(WIDTH + 1);
  localparam int SW = CNT_W + PW + 1;

  logic [PW-1:0]    pop;
  logic [CNT_W-1:0] cnt_base;
  logic [SW-1:0]    cnt_sum;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + PW'(conf_hit[i]);
    end
    cnt_base = clr_conf ? '0 : conf_cnt;
    cnt_sum  = SW'(cnt_base) + SW'(pop);
    cnt_next = (cnt_sum > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conf_cnt <= '0;
    end else begin
      conf_cnt <= cnt_next;
    end
  end
`else
  assign conf_cnt = '0;
`endif

endmodule
